// File: rtl/slow_clk_decoder_pkg.sv
// Shared types and helpers for the slow-clock mode decoder.
package slow_clk_decoder_pkg;

   localparam int unsigned MODE_W    = 3;
   localparam int unsigned CNT_W     = 32;
   localparam int unsigned NUM_MODES = 1 << MODE_W;

   typedef enum logic [1:0] {
      StIdle,
      StMeasure,
      StLocked
   } state_e;

   // Nominal half-period of mode k, widened so that tolerance arithmetic cannot overflow.
   function automatic logic [63:0] nominal_half(input logic [63:0] half_base,
                                                input int unsigned k);
      return half_base << k;
   endfunction

endpackage

// File: rtl/slow_clk_decoder_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus registered rise/fall pulses.
module slow_clk_decoder_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= d_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rise_q  <= sync2_q & ~prev_q;
         fall_q  <= ~sync2_q & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/slow_clk_decoder.sv
// Measures the half-period of the slow clock clk_in and decodes its program mode,
// flagging disagreement with the mode the clock manager reports.
module slow_clk_decoder
   import slow_clk_decoder_pkg::*;
#(
   parameter int unsigned HALF_BASE = 5000000,
   parameter int unsigned TOL       = 2,
   parameter int unsigned LOCK_CNT  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_in,
   input  logic [2:0] prog_exp,
   output logic [2:0] mode_out,
   output logic       mode_valid,
   output logic       mismatch,
   output logic       timeout
);

   localparam int unsigned LockW = $clog2(LOCK_CNT + 1);
   localparam logic [LockW-1:0] LockTarget = LockW'(LOCK_CNT);
   localparam logic [63:0] TimeoutLim = nominal_half(64'(HALF_BASE), NUM_MODES - 1) + 64'(TOL);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [LockW-1:0]    lock_q, lock_d, lock_next;
   logic [MODE_W-1:0]   cand_q, cand_d, mode_q, mode_d, dec_mode;
   logic                valid_q, valid_d, mismatch_q, mismatch_d, timeout_q, timeout_d;
   logic                rise, fall, edge_pulse, dec_hit, lock_reach, cnt_over;
   logic [63:0]         cnt_ext;

   slow_clk_decoder_sync_edge u_sync_edge (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (clk_in),
      .rise_o (rise),
      .fall_o (fall)
   );

   assign edge_pulse = rise | fall;
   assign cnt_ext    = {32'b0, cnt_q};
   assign cnt_over   = cnt_ext > TimeoutLim;

   // Lowest matching mode wins, hence the first-hit guard.
   always_comb begin
      logic [63:0] nom, lo, hi;
      dec_hit  = 1'b0;
      dec_mode = '0;
      for (int unsigned k = 0; k < NUM_MODES; k++) begin
         nom = nominal_half(64'(HALF_BASE), k);
         lo  = (nom > 64'(TOL)) ? nom - 64'(TOL) : 64'd0;
         hi  = nom + 64'(TOL);
         if (!dec_hit && cnt_ext >= lo && cnt_ext <= hi) begin
            dec_hit  = 1'b1;
            dec_mode = MODE_W'(k);
         end
      end
   end

   always_comb begin
      lock_next = LockW'(1);
      if (dec_mode == cand_q) begin
         lock_next = (lock_q == LockTarget) ? lock_q : lock_q + LockW'(1);
      end
   end

   assign lock_reach = dec_hit && (lock_next == LockTarget);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         lock_q     <= '0;
         cand_q     <= '0;
         mode_q     <= '0;
         valid_q    <= 1'b0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_q     <= lock_d;
         cand_q     <= cand_d;
         mode_q     <= mode_d;
         valid_q    <= valid_d;
         mismatch_q <= mismatch_d;
         timeout_q  <= timeout_d;
      end
   end

   // An edge always takes priority over the timeout threshold.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (edge_pulse) state_d = StMeasure;
         end
         StMeasure: begin
            if (edge_pulse) begin
               if (lock_reach) state_d = StLocked;
            end else if (cnt_over) begin
               state_d = StIdle;
            end
         end
         StLocked: begin
            if (edge_pulse) begin
               if (!dec_hit) state_d = StMeasure;
            end else if (cnt_over) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d      = cnt_q;
      lock_d     = lock_q;
      cand_d     = cand_q;
      mode_d     = mode_q;
      valid_d    = valid_q;
      timeout_d  = timeout_q;
      mismatch_d = valid_q & (mode_q != prog_exp);
      unique case (state_q)
         StMeasure, StLocked: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if (edge_pulse) begin
               cnt_d = CNT_W'(1);
               if (!dec_hit) begin
                  lock_d  = '0;
                  valid_d = 1'b0;
               end else if (state_q == StMeasure) begin
                  lock_d = lock_next;
                  cand_d = dec_mode;
                  if (lock_reach) begin
                     mode_d  = dec_mode;
                     valid_d = 1'b1;
                  end
               end else begin
                  cand_d = dec_mode;
                  mode_d = dec_mode;
               end
            end else if (cnt_over) begin
               cnt_d     = '0;
               lock_d    = '0;
               valid_d   = 1'b0;
               timeout_d = 1'b1;
            end
         end
         default: begin
            cnt_d = '0;
            if (edge_pulse) begin
               cnt_d     = CNT_W'(1);
               timeout_d = 1'b0;
            end
         end
      endcase
   end

   assign mode_out   = mode_q;
   assign mode_valid = valid_q;
   assign mismatch   = mismatch_q;
   assign timeout    = timeout_q;

endmodule
